// File: rtl/moore_pkg.sv
// Shared constants for the sequence generator and the Moore recognizer it drives:
// character codes, recognizer state codes and the generator FSM encoding.
package moore_pkg;

    localparam logic [7:0] C0 = 8'h80;
    localparam logic [7:0] C1 = 8'hF8;
    localparam logic [7:0] C2 = 8'hC0;
    localparam logic [7:0] C3 = 8'hDC;
    localparam logic [7:0] C4 = 8'hEA;
    localparam logic [7:0] C5 = 8'hCE;
    localparam logic [7:0] C6 = 8'hF1;
    localparam logic [7:0] C7 = 8'hD5;
    localparam logic [7:0] C8 = 8'hE3;

    localparam logic [3:0] S0 = 4'b0000;
    localparam logic [3:0] S1 = 4'b0001;
    localparam logic [3:0] S2 = 4'b0010;
    localparam logic [3:0] S3 = 4'b0011;
    localparam logic [3:0] S4 = 4'b0100;
    localparam logic [3:0] S5 = 4'b0101;
    localparam logic [3:0] S6 = 4'b1000;
    localparam logic [3:0] S7 = 4'b1001;
    localparam logic [3:0] S8 = 4'b1010;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RREC  = 3'd1,
        SEND1 = 3'd2,
        SEND2 = 3'd3,
        FIN   = 3'd4
    } gen_state_t;

endpackage

// File: rtl/moore_path_rom.sv
// Combinational lookup from a recognizer target state to the shortest character
// path that reaches it from S0.
module moore_path_rom
    import moore_pkg::*;
(
    input  logic [3:0] target,
    output logic       valid,
    output logic [1:0] len,
    output logic [7:0] ch1,
    output logic [7:0] ch2
);

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        valid = 1'b1;
        len   = 2'd0;
        ch1   = C0;
        ch2   = C0;
        case (target)
            S0: ;
            S1: begin len = 2'd1; ch1 = C1; end
            S2: begin len = 2'd1; ch1 = C2; end
            S3: begin len = 2'd1; ch1 = C3; end
            S4: begin len = 2'd1; ch1 = C4; end
            S5: begin len = 2'd1; ch1 = C5; end
            S6: begin len = 2'd2; ch1 = C1; ch2 = C6; end
            S7: begin len = 2'd2; ch1 = C1; ch2 = C7; end
            S8: begin len = 2'd2; ch1 = C4; ch2 = C8; end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/moore_sequence_gen.sv
// Drives a Moore recognizer from S0 to a requested state: resets it, sends the
// shortest character path with valid/ready handshaking, then pulses done.
module moore_sequence_gen
    import moore_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [3:0] target,
    input  logic       char_ready,
    output logic [7:0] entrada_out,
    output logic       char_valid,
    output logic       rec_rst,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] exp_saida
);

    gen_state_t state_q, state_d;
    logic [1:0] len_q, len_d;
    logic [7:0] ch1_q, ch1_d;
    logic [7:0] ch2_q, ch2_d;
    logic [3:0] exp_saida_q, exp_saida_d;
    logic [7:0] entrada_q, entrada_d;
    logic       char_valid_q, char_valid_d;
    logic       rec_rst_q, rec_rst_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       rom_valid;
    logic [1:0] rom_len;
    logic [7:0] rom_ch1, rom_ch2;

    moore_path_rom u_path_rom (
        .target (target),
        .valid  (rom_valid),
        .len    (rom_len),
        .ch1    (rom_ch1),
        .ch2    (rom_ch2)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        ch1_d        = ch1_q;
        ch2_d        = ch2_q;
        exp_saida_d  = exp_saida_q;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (rom_valid) begin
                        state_d     = RREC;
                        exp_saida_d = target;
                        len_d       = rom_len;
                        ch1_d       = rom_ch1;
                        ch2_d       = rom_ch2;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RREC:    state_d = (len_q == 2'd0) ? FIN : SEND1;
            SEND1:   if (char_ready) state_d = (len_q == 2'd2) ? SEND2 : FIN;
            SEND2:   if (char_ready) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered
        // in the same cycle the FSM occupies that state.
        rec_rst_d    = (state_d == RREC);
        done_d       = (state_d == FIN);
        busy_d       = (state_d != IDLE);
        char_valid_d = (state_d == SEND1) || (state_d == SEND2);
        entrada_d    = C0;
        if (state_d == SEND1) entrada_d = ch1_d;
        if (state_d == SEND2) entrada_d = ch2_d;
    end

    // NOTE: sequential state uses non-blocking assignments only; combinational logic above uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            // NOTE: the path registers are reset too, so nothing in the datapath ever holds X.
            len_q        <= 2'd0;
            ch1_q        <= C0;
            ch2_q        <= C0;
            exp_saida_q  <= S0;
            entrada_q    <= C0;
            char_valid_q <= 1'b0;
            rec_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            ch1_q        <= ch1_d;
            ch2_q        <= ch2_d;
            exp_saida_q  <= exp_saida_d;
            entrada_q    <= entrada_d;
            char_valid_q <= char_valid_d;
            rec_rst_q    <= rec_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign entrada_out = entrada_q;
    assign char_valid  = char_valid_q;
    assign rec_rst     = rec_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign exp_saida   = exp_saida_q;

endmodule

// File: tb/tb_moore_sequence_gen.sv
// Self-checking bench for moore_sequence_gen: a per-cycle expected transcript is
// built from the path table, plus a behavioural recognizer chained on the outputs.
module tb_moore_sequence_gen;

    localparam logic [7:0] K_C0 = 8'h80, K_C1 = 8'hF8, K_C2 = 8'hC0, K_C3 = 8'hDC, K_C4 = 8'hEA;
    localparam logic [7:0] K_C5 = 8'hCE, K_C6 = 8'hF1, K_C7 = 8'hD5, K_C8 = 8'hE3;

    logic       clk = 1'b0;
    logic       rst, req, char_ready;
    logic [3:0] target;
    logic [7:0] entrada_out;
    logic       char_valid, rec_rst, busy, done, err;
    logic [3:0] exp_saida;

    moore_sequence_gen dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .target      (target),
        .char_ready  (char_ready),
        .entrada_out (entrada_out),
        .char_valid  (char_valid),
        .rec_rst     (rec_rst),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .exp_saida   (exp_saida)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rec_rst;
        bit         valid;
        logic [7:0] ch;
        bit         done;
        bit         err;
        bit         busy;
        bit         ready;
    } step_t;

    int         checks = 0;
    int         errors = 0;
    int         done_seen = 0;
    int         done_expected = 0;
    logic [3:0] saida_model = 4'd0;
    logic [3:0] rec_state;

    int         plen [16];
    logic [7:0] first_ch [16];
    logic [7:0] second_ch [16];

    // Behavioural recognizer: walks the state graph on each accepted character.
    function automatic logic [3:0] rec_next(input logic [3:0] s, input logic [7:0] c);
        if (s == 4'd0 && c == K_C1) return 4'd1;
        if (s == 4'd0 && c == K_C2) return 4'd2;
        if (s == 4'd0 && c == K_C3) return 4'd3;
        if (s == 4'd0 && c == K_C4) return 4'd4;
        if (s == 4'd0 && c == K_C5) return 4'd5;
        if (s == 4'd1 && c == K_C6) return 4'd8;
        if (s == 4'd1 && c == K_C7) return 4'd9;
        if (s == 4'd4 && c == K_C8) return 4'd10;
        return 4'd0;
    endfunction

    always @(posedge clk) begin
        if (rst || rec_rst) rec_state <= 4'd0;
        else if (char_valid && char_ready) rec_state <= rec_next(rec_state, entrada_out);
    end

    always @(negedge clk) begin
        if (!rst && rst !== 1'bx) begin
            checks++;
            if (int'(done) + int'(err) + int'(rec_rst) > 1) begin
                errors++;
                $display("FAIL exclusive_pulses: done=%b err=%b rec_rst=%b, want at most one high", done, err, rec_rst);
            end
            if (done) done_seen++;
        end
    end

    task automatic init_tables();
        for (int i = 0; i < 16; i++) begin
            plen[i] = -1; first_ch[i] = K_C0; second_ch[i] = K_C0;
        end
        plen[0] = 0;
        plen[1] = 1; first_ch[1] = K_C1;
        plen[2] = 1; first_ch[2] = K_C2;
        plen[3] = 1; first_ch[3] = K_C3;
        plen[4] = 1; first_ch[4] = K_C4;
        plen[5] = 1; first_ch[5] = K_C5;
        plen[8]  = 2; first_ch[8]  = K_C1; second_ch[8]  = K_C6;
        plen[9]  = 2; first_ch[9]  = K_C1; second_ch[9]  = K_C7;
        plen[10] = 2; first_ch[10] = K_C4; second_ch[10] = K_C8;
    endtask

    // One request: builds the expected per-cycle transcript, then drives and compares it.
    task automatic run_seq(input logic [3:0] t, input int s1, input int s2, input bit noise);
        step_t q[$];
        step_t e;
        int    len = plen[t];
        logic [3:0] want_saida;
        logic [12:0] obs, expv;

        e.rec_rst = 0; e.valid = 0; e.ch = K_C0; e.done = 0; e.err = 0; e.busy = 0; e.ready = 0;
        if (len < 0) begin
            e.err = 1; e.ready = 1'($urandom_range(0, 1));
            q.push_back(e);
        end else begin
            e.rec_rst = 1; e.busy = 1; e.ready = 1'($urandom_range(0, 1));
            q.push_back(e);
            e.rec_rst = 0;
            for (int i = 0; i < len; i++) begin
                int s = (i == 0) ? s1 : s2;
                for (int k = 0; k <= s; k++) begin
                    e.valid = 1; e.ch = (i == 0) ? first_ch[t] : second_ch[t]; e.ready = (k == s);
                    q.push_back(e);
                end
            end
            e.valid = 0; e.ch = K_C0; e.done = 1; e.ready = 1'($urandom_range(0, 1));
            q.push_back(e);
            e.done = 0;
        end
        e.rec_rst = 0; e.valid = 0; e.ch = K_C0; e.done = 0; e.err = 0; e.busy = 0;
        e.ready = 1'($urandom_range(0, 1));
        q.push_back(e);

        want_saida = (len >= 0) ? t : saida_model;

        @(negedge clk);
        req = 1'b1; target = t; char_ready = 1'($urandom_range(0, 1));
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            obs  = {rec_rst, char_valid, entrada_out, done, err, busy};
            expv = {q[k].rec_rst, q[k].valid, q[k].ch, q[k].done, q[k].err, q[k].busy};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL seq_step t=%0d cycle=%0d got rr/v/ch/dn/er/bz=%h want %h", t, k + 1, obs, expv);
            end
            checks++;
            if (exp_saida !== want_saida) begin
                errors++;
                $display("FAIL exp_saida t=%0d cycle=%0d got %h want %h", t, k + 1, exp_saida, want_saida);
            end
            char_ready = q[k].ready;
            if (noise && q[k].busy) begin
                req = 1'($urandom_range(0, 1)); target = 4'($urandom_range(0, 15));
            end else begin
                req = 1'b0;
            end
        end
        req = 1'b0;

        if (len >= 0) begin
            saida_model = t;
            done_expected++;
            checks++;
            if (rec_state !== t) begin
                errors++;
                $display("FAIL recognizer_saida t=%0d got %h want %h", t, rec_state, t);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; target = 4'd3; char_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({entrada_out, char_valid, rec_rst, busy, done, err, exp_saida} !== {K_C0, 5'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_values got %h/%b%b%b%b%b/%h want 80/00000/0",
                     entrada_out, char_valid, rec_rst, busy, done, err, exp_saida);
        end
        @(negedge clk);
        rst = 1'b0; req = 1'b0; char_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rec_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b rec_rst=%b want 0 0", busy, rec_rst);
        end
        saida_model = 4'd0;
    endtask

    task automatic test_fixed_paths();
        run_seq(4'b0011, 0, 0, 1'b0);
        run_seq(4'b1010, 0, 0, 1'b0);
        run_seq(4'b1000, 3, 0, 1'b0);
        run_seq(4'b0000, 0, 0, 1'b0);
        run_seq(4'b1100, 0, 0, 1'b0);
    endtask

    task automatic test_rst_in_send2();
        @(negedge clk);
        req = 1'b1; target = 4'b1001; char_ready = 1'b1;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (char_valid !== 1'b1 || entrada_out !== K_C7) begin
            errors++;
            $display("FAIL send2_before_rst got v=%b ch=%h want 1 %h", char_valid, entrada_out, K_C7);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, char_valid, done, entrada_out, exp_saida} !== {3'b000, K_C0, 4'd0}) begin
            errors++;
            $display("FAIL rst_abort got bz/v/dn=%b%b%b ch=%h saida=%h want 000 80 0",
                     busy, char_valid, done, entrada_out, exp_saida);
        end
        rst = 1'b0;
        saida_model = 4'd0;
        repeat (3) @(negedge clk);
        run_seq(4'b0101, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_seq(4'b1001, 1, 2, 1'b1);
        run_seq(4'b0010, 2, 0, 1'b1);
        run_seq(4'b1010, 0, 1, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            run_seq(4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    endtask

    task automatic test_done_count();
        repeat (2) @(negedge clk);
        checks++;
        if (done_seen !== done_expected) begin
            errors++;
            $display("FAIL done_count got %0d want %0d", done_seen, done_expected);
        end
    endtask

    initial begin
        init_tables();
        test_reset();
        test_fixed_paths();
        test_rst_in_send2();
        test_back_to_back();
        test_random();
        test_done_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/moore_sequence_gen.md
MOORE_SEQUENCE_GEN -- requirements
Module: moore_sequence_gen

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port req, input, 1 bit: start request, sampled only in IDLE.
REQ-004 The block SHALL have port target, input, 4 bits: recognizer state code to reach (S0=0000 … S5=0101, S6=1000, S7=1001, S8=1010).
REQ-005 The block SHALL have port char_ready, input, 1 bit: downstream accepts the current character this cycle.
REQ-006 The block SHALL have port entrada_out, output, 8 bits: character bus to recognizer.
REQ-007 The block SHALL have port char_valid, output, 1 bit: entrada_out holds a sequence character.
REQ-008 The block SHALL have port rec_rst, output, 1 bit: one-cycle reset pulse to recognizer.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse for an unsupported target.
REQ-012 The block SHALL have port exp_saida, output, 4 bits: registered target, i.e. the state the recognizer must report after done.

Function
REQ-013 The block SHALL emit the shortest path from S0 to each target: S0 none; S1 C1; S2 C2; S3 C3; S4 C4; S5 C5; S6 C1,C6; S7 C1,C7; S8 C4,C8.
REQ-014 Character codes SHALL be C0=80h, C1=F8h, C2=C0h, C3=DCh, C4=EAh, C5=CEh, C6=F1h, C7=D5h, C8=E3h.
REQ-015 The FSM SHALL use states IDLE, RREC, SEND1, SEND2, FIN.
REQ-016 In IDLE, req=1 with a valid target SHALL capture target into exp_saida and the path length and characters into registers, then go to RREC.
REQ-017 In IDLE, req=1 with an invalid target (0110, 0111, 1011–1111) SHALL pulse err next cycle, leave exp_saida unchanged, and stay in IDLE.
REQ-018 RREC SHALL last exactly one cycle with rec_rst=1. It SHALL then go to FIN if length is 0, otherwise to SEND1.
REQ-019 SEND1 and SEND2 SHALL drive char_valid=1 with the stored character held stable until char_ready=1.
REQ-020 When char_ready=1, the FSM SHALL advance: SEND1 goes to SEND2 if length is 2, otherwise to FIN; SEND2 goes to FIN.
REQ-021 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-022 When char_valid=0, entrada_out SHALL be C0, the neutral character.
REQ-023 With char_ready held high, the latency from req to done SHALL be 3 cycles for length 1 and 4 cycles for length 2.
REQ-024 req while busy SHALL be ignored, not queued, and target changes while busy SHALL have no effect.
REQ-025 char_ready=1 outside SEND1/SEND2 SHALL be ignored.
REQ-026 done, err and rec_rst SHALL be mutually exclusive in every cycle.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst=1 SHALL force IDLE on the next edge from any state, aborting any sequence without a done pulse.
REQ-029 Reset values SHALL be: entrada_out=C0, char_valid=0, rec_rst=0, busy=0, done=0, err=0, exp_saida=0000.
REQ-030 rst SHALL have priority over req in the same cycle.

Structure
REQ-031 C0–C8, S0–S8 and the FSM state encoding SHALL live in shared package moore_pkg, which the recognizer also uses.
REQ-032 The target-to-path lookup SHALL be a combinational sub-module moore_path_rom with input target and outputs valid, len[1:0], ch1[7:0], ch2[7:0].

Verification
REQ-033 target=0011, req pulse, char_ready=1: the bench SHALL see rec_rst in cycle 1, entrada_out=DCh with valid in cycle 2, done in cycle 3, exp_saida=0011, and a chained recognizer reporting saida=0011.
REQ-034 target=1010, char_ready=1: the bench SHALL see the sequence EAh then E3h, then done; the recognizer SHALL report 1010.
REQ-035 target=1000, char_ready low for 3 cycles during SEND1: the bench SHALL see F8h held for 4 cycles, then F1h, then done; the recognizer SHALL report 1000.
REQ-036 target=0000: the bench SHALL see rec_rst, then done, with no char_valid; target=1100 SHALL give an err pulse with busy never asserted.
REQ-037 rst asserted in SEND2 for target=1001: the bench SHALL see IDLE next cycle, entrada_out=80h, no done, and a subsequent req=0101 completing normally.
REQ-038 A second req during busy SHALL be ignored, with exactly one done per accepted request.
